// File: rtl/stoch_bitstream_gen_pkg.sv
// Shared stochastic-computing definitions: default operand width and the
// bitstream generator state encoding.
package stoch_bitstream_gen_pkg;

   localparam int SC_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } sng_state_t;

endpackage

// File: rtl/stoch_bitstream_gen_sng_cmp.sv
// Stochastic number generator comparator: emits a 1 when the random sample
// falls below the operand, giving P(1) = thresh / 2^WIDTH.
module sng_cmp
   import stoch_bitstream_gen_pkg::*;
#(
   parameter int WIDTH = SC_WIDTH
) (
   input  logic [WIDTH-1:0] rnd,
   input  logic [WIDTH-1:0] thresh,
   output logic             bit_val
);

   assign bit_val = (rnd < thresh);

endmodule

// File: rtl/stoch_bitstream_gen.sv
// Binary-to-stochastic converter: streams 2^WIDTH bits per captured operand,
// pacing an external RNG with rng_en and a valid/ready bit interface.
module stoch_bitstream_gen
   import stoch_bitstream_gen_pkg::*;
#(
   parameter int WIDTH = SC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             rng_en,
   input  logic [WIDTH-1:0] rng_val,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic [WIDTH:0]   ones_cnt,
   output logic             done
);

   localparam logic [WIDTH:0] STREAM_LEN = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] LAST_STEP  = {1'b0, {WIDTH{1'b1}}};

   sng_state_t       state;
   sng_state_t       state_nx;
   logic [WIDTH-1:0] op_q;
   logic [WIDTH:0]   bit_cnt;
   logic             cmp_bit;
   logic             accept;
   logic             capture;
   logic             last_step;

   sng_cmp #(.WIDTH(WIDTH)) u_cmp (
      .rnd     (rng_val),
      .thresh  (op_q),
      .bit_val (cmp_bit)
   );

   // The RNG only advances when the output register is free or being drained.
   assign in_ready  = (state == IDLE);
   assign rng_en    = (state == RUN) & (~bit_valid | bit_ready);
   assign accept    = bit_valid & bit_ready;
   assign capture   = in_valid & in_ready;
   assign last_step = rng_en & (bit_cnt == LAST_STEP);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (capture)   state_nx = RUN;
         RUN:     if (last_step) state_nx = FLUSH;
         FLUSH:   if (accept)    state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand and counters; ones_cnt keeps its final value until the next capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         bit_cnt  <= '0;
         ones_cnt <= '0;
      end else if (capture) begin
         op_q     <= in_data;
         bit_cnt  <= '0;
         ones_cnt <= '0;
      end else begin
         if (rng_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (accept && bit_out && (ones_cnt != STREAM_LEN)) begin
            ones_cnt <= ones_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else if (rng_en) begin
         bit_out   <= cmp_bit;
         bit_valid <= 1'b1;
      end else if (accept) begin
         bit_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == FLUSH) & accept;
      end
   end

endmodule
